// File: rtl/median_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | median_pkg                                                               |
// | Shared types and window-size helpers for the binary median filter.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package median_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int win_count_w(input int win);
    return $clog2(win * win + 1);
  endfunction

  function automatic int MEDIAN_LIMIT(input int win);
    return (win * win - 1) / 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bit_line_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bit_line_buffer                                                          |
// | Narrow row store: combinational read and registered write at one index.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bit_line_buffer #(
  parameter int DEPTH = 129,
  parameter int WIDTH = 2,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  input  logic [WIDTH-1:0] wrData,
  output logic [WIDTH-1:0] rdData
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  assign rdData = r_mem[idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (en) begin
      r_mem[idx] <= wrData;
    end
  end

endmodule
`default_nettype wire

// File: rtl/binary_median_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | binary_median_stream                                                     |
// | Streaming WINxWIN binary median / threshold filter with zero padding.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module binary_median_stream
  import median_pkg::*;
#(
  parameter int COLS   = 128,
  parameter int ROWS   = 128,
  parameter int ADDR_W = 8,
  parameter int WIN    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              startFilter,
  input  logic              thresholdMode,
  input  logic [4:0]        threshold,
  input  logic              eventIn,
  input  logic              inValid,
  output logic              inReady,
  output logic              eventOut,
  output logic [ADDR_W-1:0] xAddress,
  output logic [ADDR_W-1:0] yAddress,
  output logic              write,
  output logic              busy,
  output logic              frameDone
);

  localparam int c_R   = (WIN - 1) / 2;
  localparam int c_SW  = ADDR_W + 1;
  localparam int c_CW  = win_count_w(WIN);
  localparam int c_LBW = $clog2(COLS + c_R);
  localparam logic [c_SW-1:0] c_COLS  = c_SW'(COLS);
  localparam logic [c_SW-1:0] c_ROWS  = c_SW'(ROWS);
  localparam logic [c_SW-1:0] c_XLAST = c_SW'(COLS + c_R - 1);
  localparam logic [c_SW-1:0] c_YLAST = c_SW'(ROWS + c_R - 1);
  localparam logic [c_SW-1:0] c_RS    = c_SW'(c_R);
  localparam logic [c_CW-1:0] c_LIMIT = c_CW'(MEDIAN_LIMIT(WIN));

  generate
    if ((WIN != 3 && WIN != 5) || COLS < WIN || ROWS < WIN ||
        (1 << ADDR_W) < COLS || (1 << ADDR_W) < ROWS) begin : g_badParams
      $error("binary_median_stream: illegal WIN/COLS/ROWS/ADDR_W");
    end
  endgenerate

  state_t          r_state, w_nextState;
  logic [c_SW-1:0] r_sx, r_sy;
  logic            r_mode;
  logic [4:0]      r_thr;
  logic            w_inGrid, w_advance, w_inBit, w_lastPos, w_emit;
  logic [WIN-2:0]  w_lbRd, w_lbWr;
  logic [WIN-1:0]  w_col;
  logic [WIN-1:0]  r_win [WIN];
  logic [WIN-1:0]  w_win [WIN];
  logic [c_CW-1:0] w_count;
  logic            w_pixel;
  logic            r_eventOut, r_write, r_frameDone;
  logic [ADDR_W-1:0] r_x, r_y;

  assign w_inGrid  = (r_sx < c_COLS) && (r_sy < c_ROWS);
  assign inReady   = (r_state == SCAN) && w_inGrid;
  // Pad positions advance unconditionally; grid positions wait for data.
  assign w_advance = (r_state == SCAN) && (!w_inGrid || inValid);
  assign w_inBit   = w_inGrid && eventIn;
  assign w_lastPos = (r_sx == c_XLAST) && (r_sy == c_YLAST);
  assign w_emit    = w_advance && (r_sx >= c_RS) && (r_sy >= c_RS);
  assign busy      = (r_state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (startFilter) w_nextState = SCAN;
      SCAN:    if (w_advance && w_lastPos) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sx   <= '0;
      r_sy   <= '0;
      r_mode <= 1'b0;
      r_thr  <= '0;
    end else if (r_state == IDLE && startFilter) begin
      r_sx   <= '0;
      r_sy   <= '0;
      r_mode <= thresholdMode;
      r_thr  <= threshold;
    end else if (w_advance) begin
      if (r_sx == c_XLAST) begin
        r_sx <= '0;
        r_sy <= w_lastPos ? '0 : r_sy + 1'b1;
      end else begin
        r_sx <= r_sx + 1'b1;
      end
    end
  end

  bit_line_buffer #(
    .DEPTH (COLS + c_R),
    .WIDTH (WIN - 1),
    .IDX_W (c_LBW)
  ) u_lineBuf (
    .clk    (clk),
    .reset  (reset),
    .en     (w_advance),
    .idx    (r_sx[c_LBW-1:0]),
    .wrData (w_lbWr),
    .rdData (w_lbRd)
  );

  assign w_lbWr = {w_lbRd[WIN-3:0], w_inBit};

  // Rows above the frame top may still hold the previous frame.
  always_comb begin
    w_col = {w_lbRd, w_inBit};
    for (int k = 1; k < WIN; k++) begin
      if (r_sy < c_SW'(k)) w_col[k] = 1'b0;
    end
  end

  // Clearing older columns at sx==0 zero-pads the left edge.
  always_comb begin
    w_win[0] = w_col;
    for (int j = 1; j < WIN; j++) begin
      w_win[j] = (r_sx == '0) ? '0 : r_win[j-1];
    end
  end

  always_comb begin
    w_count = '0;
    for (int j = 0; j < WIN; j++) begin
      for (int k = 0; k < WIN; k++) begin
        w_count = w_count + c_CW'(w_win[j][k]);
      end
    end
    if (r_mode) w_pixel = (6'(w_count) >= 6'(r_thr));
    else        w_pixel = (w_count > c_LIMIT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < WIN; j++) r_win[j] <= '0;
    end else if (w_advance) begin
      for (int j = 0; j < WIN; j++) r_win[j] <= w_win[j];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_write     <= 1'b0;
      r_eventOut  <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_frameDone <= 1'b0;
    end else begin
      r_write     <= w_emit;
      r_frameDone <= (r_state == DONE);
      if (w_emit) begin
        r_eventOut <= w_pixel;
        r_x        <= ADDR_W'(r_sx - c_RS);
        r_y        <= ADDR_W'(r_sy - c_RS);
      end
    end
  end

  assign write     = r_write;
  assign eventOut  = r_eventOut;
  assign xAddress  = r_x;
  assign yAddress  = r_y;
  assign frameDone = r_frameDone;

endmodule
`default_nettype wire

// File: tb/tb_binary_median_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_binary_median_stream                                                  |
// | Directed bench: 8x8 WIN=3 instance and 8x6 WIN=5 instance.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_binary_median_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetN;

  logic st3, mode3, ev3, iv3, rdy3, eo3, wr3, busy3, done3;
  logic [4:0] thr3;
  logic [2:0] xa3, ya3;
  logic st5, mode5, ev5, iv5, rdy5, eo5, wr5, busy5, done5;
  logic [4:0] thr5;
  logic [2:0] xa5, ya5;

  binary_median_stream #(.COLS(8), .ROWS(8), .ADDR_W(3), .WIN(3)) dut3 (
    .clk(clk), .reset(resetN), .startFilter(st3), .thresholdMode(mode3),
    .threshold(thr3), .eventIn(ev3), .inValid(iv3), .inReady(rdy3),
    .eventOut(eo3), .xAddress(xa3), .yAddress(ya3), .write(wr3),
    .busy(busy3), .frameDone(done3));

  binary_median_stream #(.COLS(8), .ROWS(6), .ADDR_W(3), .WIN(5)) dut5 (
    .clk(clk), .reset(resetN), .startFilter(st5), .thresholdMode(mode5),
    .threshold(thr5), .eventIn(ev5), .inValid(iv5), .inReady(rdy5),
    .eventOut(eo5), .xAddress(xa5), .yAddress(ya5), .write(wr5),
    .busy(busy5), .frameDone(done5));

  int checks = 0;
  int errors = 0;

  logic img3 [8][8];
  logic out3 [8][8];
  logic img5 [6][8];
  logic out5 [6][8];
  logic ref5 [6][8];
  int wr3Cnt = 0, done3Cnt = 0, ord3Err = 0, idx3 = 0, doneBad3 = 0;
  int wr5Cnt = 0, done5Cnt = 0, ord5Err = 0, idx5 = 0, doneBad5 = 0;
  int rdyLow5 = 0, busyCyc5 = 0;

  // Output monitors: capture frames and check raster order as writes arrive.
  always @(negedge clk) begin
    if (!resetN) begin
      idx3 = 0;
    end else begin
      if (wr3) begin
        if (int'(xa3) != idx3 % 8 || int'(ya3) != idx3 / 8) ord3Err++;
        out3[ya3][xa3] = eo3;
        idx3++;
        wr3Cnt++;
      end
      if (done3) begin
        done3Cnt++;
        if (idx3 != 64 || busy3) doneBad3++;
        idx3 = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!resetN) begin
      idx5 = 0;
    end else begin
      if (busy5) begin
        busyCyc5++;
        if (!rdy5) rdyLow5++;
      end
      if (wr5) begin
        if (int'(xa5) != idx5 % 8 || int'(ya5) != idx5 / 8) ord5Err++;
        out5[ya5][xa5] = eo5;
        idx5++;
        wr5Cnt++;
      end
      if (done5) begin
        done5Cnt++;
        if (idx5 != 48 || busy5) doneBad5++;
        idx5 = 0;
      end
    end
  end

  function automatic int ones3();
    int n = 0;
    for (int y = 0; y < 8; y++) for (int x = 0; x < 8; x++) n += int'(out3[y][x]);
    return n;
  endfunction

  function automatic int ones5();
    int n = 0;
    for (int y = 0; y < 6; y++) for (int x = 0; x < 8; x++) n += int'(out5[y][x]);
    return n;
  endfunction

  task automatic fill3(input logic v);
    for (int y = 0; y < 8; y++) for (int x = 0; x < 8; x++) img3[y][x] = v;
  endtask

  task automatic run3(input int stopAt, output bit ok, output logic busyAfter);
    int guard;
    int d0;
    ok = 1'b1;
    d0 = done3Cnt;
    @(posedge clk); #1 st3 = 1'b1;
    @(posedge clk); #1 st3 = 1'b0;
    busyAfter = busy3;
    for (int p = 0; p < 64 && p != stopAt; p++) begin
      ev3 = img3[p/8][p%8];
      iv3 = 1'b1;
      guard = 0;
      while (!rdy3 && guard < 20) begin @(posedge clk); #1; guard++; end
      if (guard >= 20) ok = 1'b0;
      @(posedge clk); #1;
    end
    iv3 = 1'b0;
    ev3 = 1'b0;
    if (stopAt < 0) begin
      guard = 0;
      while (done3Cnt == d0 && guard < 300) begin @(posedge clk); #1; guard++; end
      if (guard >= 300) ok = 1'b0;
      repeat (3) @(posedge clk);
      #1;
    end
  endtask

  task automatic run5(input bit gaps, input bit midStart, output bit ok);
    int guard;
    int d0;
    ok = 1'b1;
    d0 = done5Cnt;
    @(posedge clk); #1 st5 = 1'b1;
    @(posedge clk); #1 st5 = 1'b0;
    for (int p = 0; p < 48; p++) begin
      if (gaps) begin
        iv5 = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      if (midStart && p == 20) st5 = 1'b1;
      ev5 = img5[p/8][p%8];
      iv5 = 1'b1;
      guard = 0;
      while (!rdy5 && guard < 50) begin @(posedge clk); #1; guard++; end
      if (guard >= 50) ok = 1'b0;
      @(posedge clk); #1;
      st5 = 1'b0;
    end
    iv5 = 1'b0;
    ev5 = 1'b0;
    guard = 0;
    while (done5Cnt == d0 && guard < 500) begin @(posedge clk); #1; guard++; end
    if (guard >= 500) ok = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rdy3, eo3, wr3, busy3, done3} !== 5'b0) begin
      errors++; $display("FAIL reset_flags3: got %b expected 00000", {rdy3, eo3, wr3, busy3, done3});
    end
    checks++;
    if ({xa3, ya3} !== 6'b0) begin
      errors++; $display("FAIL reset_addr3: got %b expected 000000", {xa3, ya3});
    end
    checks++;
    if ({rdy5, eo5, wr5, busy5, done5, xa5, ya5} !== 11'b0) begin
      errors++; $display("FAIL reset_all5: got %b expected 0", {rdy5, eo5, wr5, busy5, done5, xa5, ya5});
    end
    resetN = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_all_zero();
    bit ok; logic b; int w0, d0, e0, f0;
    fill3(1'b0); mode3 = 1'b0; thr3 = 5'd0;
    w0 = wr3Cnt; d0 = done3Cnt; e0 = ord3Err; f0 = doneBad3;
    run3(-1, ok, b);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL zero_frame_complete: got %0d expected 1", ok); end
    checks++;
    if (b !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b expected 1", b); end
    checks++;
    if (wr3Cnt - w0 != 64) begin errors++; $display("FAIL zero_writes: got %0d expected 64", wr3Cnt - w0); end
    checks++;
    if (ord3Err - e0 != 0) begin errors++; $display("FAIL zero_raster_order: got %0d bad expected 0", ord3Err - e0); end
    checks++;
    if (done3Cnt - d0 != 1) begin errors++; $display("FAIL zero_frame_done: got %0d expected 1", done3Cnt - d0); end
    checks++;
    if (doneBad3 - f0 != 0) begin errors++; $display("FAIL done_after_last_write: got %0d bad expected 0", doneBad3 - f0); end
    checks++;
    if (ones3() != 0) begin errors++; $display("FAIL zero_ones: got %0d expected 0", ones3()); end
  endtask

  task automatic test_isolated();
    bit ok; logic b;
    fill3(1'b0); img3[3][3] = 1'b1; mode3 = 1'b0;
    run3(-1, ok, b);
    checks++;
    if (ok !== 1'b1 || out3[3][3] !== 1'b0) begin
      errors++; $display("FAIL isolated_center: got %b ok %0d expected 0", out3[3][3], ok);
    end
    checks++;
    if (ones3() != 0) begin errors++; $display("FAIL isolated_ones: got %0d expected 0", ones3()); end
  endtask

  task automatic test_block();
    bit ok; logic b; logic exp;
    fill3(1'b0);
    for (int y = 3; y <= 5; y++) for (int x = 3; x <= 5; x++) img3[y][x] = 1'b1;
    mode3 = 1'b0;
    run3(-1, ok, b);
    // centre 9, edge neighbours 6, corner neighbours 4
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        exp = (dx == 0 || dy == 0);
        checks++;
        if (out3[4+dy][4+dx] !== exp) begin
          errors++;
          $display("FAIL block_pixel(%0d,%0d): got %b expected %b", 4+dx, 4+dy, out3[4+dy][4+dx], exp);
        end
      end
    end
    checks++;
    if (ok !== 1'b1 || ones3() != 5) begin errors++; $display("FAIL block_ones: got %0d expected 5", ones3()); end
  endtask

  task automatic test_ones_mode0();
    bit ok; logic b;
    fill3(1'b1); mode3 = 1'b0;
    run3(-1, ok, b);
    checks++;
    if (out3[0][0] !== 1'b0) begin errors++; $display("FAIL ones_corner00: got %b expected 0", out3[0][0]); end
    checks++;
    if (out3[3][0] !== 1'b1) begin errors++; $display("FAIL ones_edge03: got %b expected 1", out3[3][0]); end
    checks++;
    if (out3[3][3] !== 1'b1) begin errors++; $display("FAIL ones_interior: got %b expected 1", out3[3][3]); end
    checks++;
    if (out3[0][7] !== 1'b0) begin errors++; $display("FAIL ones_corner70: got %b expected 0", out3[0][7]); end
    checks++;
    if (ok !== 1'b1 || ones3() != 60) begin errors++; $display("FAIL ones_total: got %0d expected 60", ones3()); end
  endtask

  task automatic test_threshold();
    bit ok; logic b;
    fill3(1'b1); mode3 = 1'b1; thr3 = 5'd4;
    run3(-1, ok, b);
    checks++;
    if (out3[0][0] !== 1'b1) begin errors++; $display("FAIL thr4_corner: got %b expected 1", out3[0][0]); end
    checks++;
    if (ones3() != 64) begin errors++; $display("FAIL thr4_total: got %0d expected 64", ones3()); end
    thr3 = 5'd9;
    run3(-1, ok, b);
    checks++;
    if (ones3() != 36) begin errors++; $display("FAIL thr9_total: got %0d expected 36", ones3()); end
    thr3 = 5'd10;
    run3(-1, ok, b);
    checks++;
    if (ones3() != 0) begin errors++; $display("FAIL thr10_total: got %0d expected 0", ones3()); end
    fill3(1'b0); thr3 = 5'd0;
    run3(-1, ok, b);
    checks++;
    if (ok !== 1'b1 || ones3() != 64) begin errors++; $display("FAIL thr0_total: got %0d expected 64", ones3()); end
    mode3 = 1'b0;
  endtask

  task automatic test_win5_ones();
    bit ok;
    for (int y = 0; y < 6; y++) for (int x = 0; x < 8; x++) img5[y][x] = 1'b1;
    mode5 = 1'b0; thr5 = 5'd0;
    run5(1'b0, 1'b0, ok);
    checks++;
    if (out5[0][0] !== 1'b0) begin errors++; $display("FAIL w5_corner: got %b expected 0", out5[0][0]); end
    checks++;
    if (out5[1][0] !== 1'b0) begin errors++; $display("FAIL w5_count12: got %b expected 0", out5[1][0]); end
    checks++;
    if (out5[2][0] !== 1'b1) begin errors++; $display("FAIL w5_count15: got %b expected 1", out5[2][0]); end
    checks++;
    if (out5[1][1] !== 1'b1) begin errors++; $display("FAIL w5_count16: got %b expected 1", out5[1][1]); end
    checks++;
    if (ok !== 1'b1 || ones5() != 36) begin errors++; $display("FAIL w5_total: got %0d expected 36", ones5()); end
  endtask

  task automatic test_back_to_back();
    bit ok; int w0, d0, e0, r0, b0, diffs;
    for (int y = 0; y < 6; y++) for (int x = 0; x < 8; x++) img5[y][x] = ((x * 3 + y * 5) % 7) < 3;
    mode5 = 1'b0;
    r0 = rdyLow5; b0 = busyCyc5;
    run5(1'b0, 1'b0, ok);
    for (int y = 0; y < 6; y++) for (int x = 0; x < 8; x++) ref5[y][x] = out5[y][x];
    checks++;
    if (busyCyc5 - b0 != 81) begin errors++; $display("FAIL nogap_busy_cycles: got %0d expected 81", busyCyc5 - b0); end
    checks++;
    if (rdyLow5 - r0 != 33) begin errors++; $display("FAIL nogap_ready_low: got %0d expected 33", rdyLow5 - r0); end
    w0 = wr5Cnt; d0 = done5Cnt; e0 = ord5Err; r0 = rdyLow5;
    for (int y = 0; y < 6; y++) for (int x = 0; x < 8; x++) out5[y][x] = ~ref5[y][x];
    run5(1'b1, 1'b1, ok);
    diffs = 0;
    for (int y = 0; y < 6; y++) for (int x = 0; x < 8; x++) if (out5[y][x] !== ref5[y][x]) diffs++;
    checks++;
    if (ok !== 1'b1 || diffs != 0) begin errors++; $display("FAIL gap_vs_nogap: got %0d diffs expected 0", diffs); end
    checks++;
    if (wr5Cnt - w0 != 48 || ord5Err - e0 != 0) begin
      errors++; $display("FAIL gap_writes: got %0d (order bad %0d) expected 48", wr5Cnt - w0, ord5Err - e0);
    end
    checks++;
    if (done5Cnt - d0 != 1) begin errors++; $display("FAIL gap_frame_done: got %0d expected 1", done5Cnt - d0); end
    checks++;
    if (rdyLow5 - r0 != 33) begin errors++; $display("FAIL gap_ready_low: got %0d expected 33", rdyLow5 - r0); end
  endtask

  task automatic test_reset_mid();
    bit ok; logic b; int w0, d0, e0;
    fill3(1'b1); mode3 = 1'b0;
    d0 = done3Cnt;
    run3(20, ok, b);
    #3 resetN = 1'b0;
    #1;
    checks++;
    if ({wr3, busy3, rdy3, eo3, done3, xa3, ya3} !== 11'b0) begin
      errors++; $display("FAIL midreset_outputs: got %b expected 0", {wr3, busy3, rdy3, eo3, done3, xa3, ya3});
    end
    repeat (3) @(posedge clk);
    #1 resetN = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done3Cnt != d0) begin errors++; $display("FAIL midreset_no_done: got %0d expected %0d", done3Cnt, d0); end
    fill3(1'b0);
    w0 = wr3Cnt; d0 = done3Cnt; e0 = ord3Err;
    run3(-1, ok, b);
    checks++;
    if (ok !== 1'b1 || wr3Cnt - w0 != 64 || ord3Err - e0 != 0 || done3Cnt - d0 != 1) begin
      errors++; $display("FAIL after_reset_frame: got writes %0d done %0d expected 64 1", wr3Cnt - w0, done3Cnt - d0);
    end
    checks++;
    if (ones3() != 0) begin errors++; $display("FAIL after_reset_stale: got %0d ones expected 0", ones3()); end
  endtask

  initial begin
    resetN = 1'b0;
    {st3, mode3, ev3, iv3, thr3} = '0;
    {st5, mode5, ev5, iv5, thr5} = '0;
    test_reset();
    test_all_zero();
    test_isolated();
    test_block();
    test_ones_mode0();
    test_threshold();
    test_win5_ones();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
